// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_ADDR_SIZE  = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data stages, one transaction outstanding.
// Latency: request sampled in cycle 0 -> done pulse in cycle 3 minimum (+1 per gnt or rvalid wait).
// Backpressure: mem_req held until mem_gnt; requesters see stall_* until their done pulse.
//
// Ports:
//   clk, reset                          clock (rising edge), async active-low reset
//   if_req/if_addr                      fetch request; if_rdata/if_done/stall_if back to fetch
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata data request; dm_rdata/dm_done/stall_dm back to memory stage
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  registered request to memory, mem_gnt accepts it
//   mem_rvalid/mem_rdata                one response per grant (read data or write ack)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  // fetch port
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic [XLEN-1:0]      if_rdata,
  output logic                 if_done,
  output logic                 stall_if,
  // data port
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [3:0]           dm_be,
  input  logic [ADDR_SIZE-1:0] dm_addr,
  input  logic [XLEN-1:0]      dm_wdata,
  output logic [XLEN-1:0]      dm_rdata,
  output logic                 dm_done,
  output logic                 stall_dm,
  // memory side
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arbState_t        state, nextState;
  owner_t           owner;
  logic [CNT_W-1:0] starveCnt;

  logic ifReqM, dmReqM;
  logic pickIf, pickDm;
  logic launch;
  logic rspTake;

  // A port completing this cycle still holds req high; masking keeps it from
  // being re-granted on the stale request, which gives the other port the slot.
  assign ifReqM = if_req & ~if_done;
  assign dmReqM = dm_req & ~dm_done;

  // Data wins ties unless fetch has lost STARVE_MAX decisions in a row.
  assign pickIf = ifReqM & (~dmReqM | (starveCnt == STARVE_LIM));
  assign pickDm = dmReqM & ~pickIf;

  assign launch  = (state == ARB_IDLE) & (pickIf | pickDm);
  assign rspTake = (state == ARB_WAIT) & mem_rvalid;

  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= nextState;
  end

  // Next-state logic; responses outside WAIT are ignored.
  always_comb begin
    nextState = state;
    case (state)
      ARB_IDLE: if (pickIf | pickDm) nextState = ARB_REQ;
      ARB_REQ:  if (mem_gnt)         nextState = ARB_WAIT;
      ARB_WAIT: if (mem_rvalid)      nextState = ARB_IDLE;
      default:                       nextState = ARB_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_req = (state == ARB_REQ);
  end

  // Owner and request fields are captured once at launch and held through WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_DM;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (launch) begin
      if (pickIf) begin
        owner     <= OWN_IF;
        mem_we    <= 1'b0;
        mem_be    <= 4'b1111;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else begin
        owner     <= OWN_DM;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end
    end
  end

  // Starvation counter: counts consecutive decisions fetch lost, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (launch) begin
      if (pickIf)
        starveCnt <= '0;
      else if (ifReqM && (starveCnt != STARVE_LIM))
        starveCnt <= starveCnt + 1'b1;
    end
  end

  // Completion: done pulses one cycle after the response, read data held
  // until the same port's next completion. Store acks leave dm_rdata alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= rspTake & (owner == OWN_IF);
      dm_done <= rspTake & (owner == OWN_DM);
      if (rspTake && (owner == OWN_IF))
        if_rdata <= mem_rdata;
      if (rspTake && (owner == OWN_DM) && !mem_we)
        dm_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with expected grants and read data queued up front.
// Latency: n/a.
// Backpressure: a behavioural memory with programmable grant and response delays.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_done, stall_if;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, stall_dm;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .ADDR_SIZE(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [3:0]  b;
    logic [31:0] d;
  } gnt_t;

  gnt_t        expGnt[$];
  logic [31:0] expIf[$];
  logic [31:0] expDm[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic pushGnt(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    gnt_t g;
    g.a = a; g.w = w; g.b = b; g.d = d;
    expGnt.push_back(g);
  endtask

  // ---------------- behavioural memory ----------------
  logic [31:0] memArr [logic [31:0]];
  int          gntDelay = 0;
  int          rvDelay  = 0;
  logic        forceRv  = 1'b0;
  logic [31:0] forceData = 32'h0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : 32'h0;
  endfunction

  initial begin
    logic        pending;
    logic [31:0] pendData;
    logic [31:0] w;
    int          gntWait;
    int          rvCnt;
    pending = 1'b0; pendData = 32'h0; gntWait = 0; rvCnt = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (forceRv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = forceData;
      end else if (pending) begin
        if (rvCnt == rvDelay) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pendData;
          pending    = 1'b0;
        end else begin
          rvCnt++;
        end
      end
      if (mem_req && !pending) begin
        if (gntWait == gntDelay) begin
          mem_gnt = 1'b1;
          gntWait = 0;
          pending = 1'b1;
          rvCnt   = 0;
          if (mem_we) begin
            w = memRead(mem_addr);
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            memArr[mem_addr] = w;
            pendData = 32'hBAD0_0000;
          end else begin
            pendData = memRead(mem_addr);
          end
        end else begin
          gntWait++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    gnt_t g;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req && mem_gnt) begin
          if (expGnt.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL grant: unexpected grant addr %h", mem_addr);
          end else begin
            g = expGnt.pop_front();
            chk("grant addr", mem_addr, g.a);
            chk1("grant we", mem_we, g.w);
            chk("grant be", 32'(mem_be), 32'(g.b));
            chk("grant wdata", mem_wdata, g.d);
          end
        end
        if (if_done) begin
          if (expIf.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL if_done: unexpected pulse, if_rdata %h", if_rdata);
          end else begin
            chk("if_rdata", if_rdata, expIf.pop_front());
          end
        end
        if (dm_done) begin
          if (expDm.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL dm_done: unexpected pulse, dm_rdata %h", dm_rdata);
          end else begin
            chk("dm_rdata", dm_rdata, expDm.pop_front());
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic waitDone(input logic isIf, input int maxCyc, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      seen = isIf ? if_done : dm_done;
    end
    chk1(nm, seen, 1'b1);
  endtask

  // Hold both requests, releasing each after its own done pulse.
  task automatic drainBoth(input string nm);
    logic dDone, iDone;
    dDone = 1'b0; iDone = 1'b0;
    for (int i = 0; i < 30 && !(dDone && iDone); i++) begin
      @(negedge clk);
      if (dm_done) dDone = 1'b1;
      if (if_done) iDone = 1'b1;
      @(posedge clk); #1;
      if (dDone) dm_req = 1'b0;
      if (iDone) if_req = 1'b0;
    end
    chk1(nm, dDone & iDone, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0; dm_wdata = 32'h0;
    memArr[32'h100]  = 32'h0050_0093;
    memArr[32'h104]  = 32'h0010_8093;
    memArr[32'h300]  = 32'h00A0_0113;
    memArr[32'h2000] = 32'h1111_1111;
    memArr[32'h2004] = 32'h2222_2222;
    for (int k = 0; k < 5; k++) memArr[32'h1000 + 4*k] = 32'hCAFE_0000 + k;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk1("rst mem_req", mem_req, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk("rst mem_be", 32'(mem_be), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    chk1("rst if_done", if_done, 1'b0);
    chk1("rst dm_done", dm_done, 1'b0);
    chk("rst state", 32'(dut.state), 32'(ARB_IDLE));
    chk("rst starveCnt", 32'(dut.starveCnt), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // lone fetch
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    pushGnt(32'h100, 1'b0, 4'hF, 32'h0);
    expIf.push_back(32'h0050_0093);
    @(negedge clk);
    chk1("fetch c0 stall_if", stall_if, 1'b1);
    chk1("fetch c0 mem_req", mem_req, 1'b0);
    @(negedge clk);
    chk1("fetch c1 mem_req", mem_req, 1'b1);
    chk("fetch c1 mem_addr", mem_addr, 32'h100);
    chk1("fetch c1 mem_we", mem_we, 1'b0);
    chk1("fetch c1 stall_if", stall_if, 1'b1);
    @(negedge clk);
    chk1("fetch c2 mem_req", mem_req, 1'b0);
    chk1("fetch c2 stall_if", stall_if, 1'b1);
    @(negedge clk);
    chk1("fetch c3 if_done", if_done, 1'b1);
    chk("fetch c3 if_rdata", if_rdata, 32'h0050_0093);
    chk1("fetch c3 stall_if", stall_if, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk1("fetch c4 if_done", if_done, 1'b0);
    chk("fetch c4 if_rdata hold", if_rdata, 32'h0050_0093);

    // store with grant delayed two cycles
    gntDelay = 2;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    pushGnt(32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    expDm.push_back(32'h0);
    @(negedge clk);
    chk1("store c0 stall_dm", stall_dm, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk1("store hold mem_req", mem_req, 1'b1);
      chk1("store hold mem_we", mem_we, 1'b1);
      chk("store hold mem_be", 32'(mem_be), 32'h3);
      chk("store hold mem_addr", mem_addr, 32'h2000);
      chk("store hold mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    chk1("store c4 mem_req", mem_req, 1'b0);
    chk1("store c4 stall_dm", stall_dm, 1'b1);
    @(negedge clk);
    chk1("store c5 dm_done", dm_done, 1'b1);
    chk("store dm_rdata unchanged", dm_rdata, 32'h0);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'hF; dm_wdata = 32'h0;
    gntDelay = 0;

    // back-to-back loads on the data port
    @(posedge clk); #1;
    dm_req = 1'b1; dm_addr = 32'h2000;
    pushGnt(32'h2000, 1'b0, 4'hF, 32'h0);
    expDm.push_back(32'h1111_BEEF);
    waitDone(1'b0, 10, "b2b first done");
    @(posedge clk); #1;
    dm_addr = 32'h2004;
    pushGnt(32'h2004, 1'b0, 4'hF, 32'h0);
    expDm.push_back(32'h2222_2222);
    @(negedge clk);
    chk1("b2b bubble mem_req", mem_req, 1'b0);
    @(negedge clk);
    chk1("b2b second mem_req", mem_req, 1'b1);
    chk("b2b second mem_addr", mem_addr, 32'h2004);
    waitDone(1'b0, 10, "b2b second done");
    @(posedge clk); #1;
    dm_req = 1'b0;

    // both held: data first, fetch takes the data port's done cycle
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_addr = 32'h2004;
    pushGnt(32'h2004, 1'b0, 4'hF, 32'h0);
    pushGnt(32'h104, 1'b0, 4'hF, 32'h0);
    expDm.push_back(32'h2222_2222);
    expIf.push_back(32'h0010_8093);
    @(negedge clk);
    @(negedge clk);
    chk("contend first owner addr", mem_addr, 32'h2004);
    chk("contend starveCnt", 32'(dut.starveCnt), 32'h1);
    drainBoth("contend both done");

    // fetch loses four decisions, then is forced ahead of data
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      dm_req = 1'b1; dm_addr = 32'h1000 + 4*k;
      if_req = 1'b1; if_addr = 32'h300;
      pushGnt(32'h1000 + 4*k, 1'b0, 4'hF, 32'h0);
      expDm.push_back(32'hCAFE_0000 + k);
      @(negedge clk);
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      chk("starve dm addr", mem_addr, 32'h1000 + 4*k);
      chk("starve cnt", 32'(dut.starveCnt), 32'(k + 1));
      waitDone(1'b0, 10, "starve dm done");
      @(posedge clk); #1;
      dm_req = 1'b0;
    end
    @(posedge clk); #1;
    dm_req = 1'b1; dm_addr = 32'h1010;
    if_req = 1'b1; if_addr = 32'h300;
    pushGnt(32'h300, 1'b0, 4'hF, 32'h0);
    pushGnt(32'h1010, 1'b0, 4'hF, 32'h0);
    expIf.push_back(32'h00A0_0113);
    expDm.push_back(32'hCAFE_0004);
    @(negedge clk);
    @(negedge clk);
    chk("starve forced if addr", mem_addr, 32'h300);
    chk("starve cnt cleared", 32'(dut.starveCnt), 32'h0);
    drainBoth("starve final both done");

    // stray response while idle
    @(negedge clk);
    forceData = 32'hFFFF_FFFF;
    forceRv   = 1'b1;
    @(negedge clk);
    forceRv = 1'b0;
    @(negedge clk);
    chk1("stray if_done", if_done, 1'b0);
    chk1("stray dm_done", dm_done, 1'b0);
    chk("stray if_rdata", if_rdata, 32'h00A0_0113);
    chk("stray dm_rdata", dm_rdata, 32'hCAFE_0004);
    chk("stray state", 32'(dut.state), 32'(ARB_IDLE));

    // reset while waiting for the response
    rvDelay = 3;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h108;
    pushGnt(32'h108, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstwait state before", 32'(dut.state), 32'(ARB_WAIT));
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk1("rstwait mem_req", mem_req, 1'b0);
    chk("rstwait mem_addr", mem_addr, 32'h0);
    chk("rstwait mem_be", 32'(mem_be), 32'h0);
    chk("rstwait if_rdata", if_rdata, 32'h0);
    chk("rstwait dm_rdata", dm_rdata, 32'h0);
    chk("rstwait state", 32'(dut.state), 32'(ARB_IDLE));
    chk1("rstwait stall_if", stall_if, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("rstwait late if_done", if_done, 1'b0);
      chk1("rstwait late dm_done", dm_done, 1'b0);
      chk("rstwait late if_rdata", if_rdata, 32'h0);
      chk("rstwait late state", 32'(dut.state), 32'(ARB_IDLE));
    end
    rvDelay = 0;

    @(negedge clk);
    chk("leftover grants", 32'(expGnt.size()), 32'h0);
    chk("leftover if responses", 32'(expIf.size()), 32'h0);
    chk("leftover dm responses", 32'(expDm.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
